// File: rtl/game_timer.sv
// Countdown game timer: BCD mm:ss countdown with start/pause/bonus/load control
// and a registered, multiplexed four-digit seven-segment display driver.
module game_timer #(
    parameter logic [7:0]  START_MM = 8'h02,
    parameter logic [7:0]  START_SS = 8'h00,
    parameter int unsigned SCAN_W   = 17
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       start,
    input  logic       pause,
    input  logic       load,
    input  logic       bonus,
    output logic [7:0] mm,
    output logic [7:0] ss,
    output logic       running,
    output logic       expired,
    output logic       timeout,
    output logic [3:0] an,
    output logic [6:0] seg
);

    localparam logic [15:0] T_ZERO = 16'h0000;
    localparam logic [15:0] T_MAX  = 16'h9959;

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, EXPIRED} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [7:0]        mm_nxt;
    logic [7:0]        ss_nxt;
    logic              timeout_nxt;
    logic [15:0]       cur_t;
    logic [15:0]       t_dec;
    logic [15:0]       t_add;
    logic [15:0]       t_both;
    logic [SCAN_W-1:0] scan_cnt;
    logic [1:0]        digit_idx_c;
    logic [3:0]        nib_c;
    logic [3:0]        an_c;
    logic [6:0]        seg_c;

    // BCD mm:ss minus one second, borrowing through every digit.
    function automatic logic [15:0] bcd_dec(input logic [15:0] t);
        logic [3:0] mt, mo, st, so;
        {mt, mo, st, so} = t;
        if (so != 4'd0) begin
            so = so - 4'd1;
        end else begin
            so = 4'd9;
            if (st != 4'd0) begin
                st = st - 4'd1;
            end else begin
                st = 4'd5;
                if (mo != 4'd0) begin
                    mo = mo - 4'd1;
                end else begin
                    mo = 4'd9;
                    mt = mt - 4'd1;
                end
            end
        end
        return {mt, mo, st, so};
    endfunction

    // BCD mm:ss plus ten seconds, saturating at 99:59.
    function automatic logic [15:0] bcd_add10(input logic [15:0] t);
        logic [3:0] mt, mo, st, so;
        logic       sat;
        {mt, mo, st, so} = t;
        sat = 1'b0;
        if (st != 4'd5) begin
            st = st + 4'd1;
        end else begin
            st = 4'd0;
            if (mo != 4'd9) begin
                mo = mo + 4'd1;
            end else begin
                mo = 4'd0;
                if (mt != 4'd9) mt = mt + 4'd1;
                else            sat = 1'b1;
            end
        end
        return sat ? T_MAX : {mt, mo, st, so};
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // Decrement first so a combined bonus+tick saturates on the net +9 s.
    assign cur_t  = {mm, ss};
    assign t_dec  = bcd_dec(cur_t);
    assign t_add  = bcd_add10(cur_t);
    assign t_both = bcd_add10(t_dec);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state and next time value; load beats start/pause beats bonus/tick.
    always_comb begin
        state_nxt   = state;
        mm_nxt      = mm;
        ss_nxt      = ss;
        timeout_nxt = 1'b0;
        if (load) begin
            state_nxt = IDLE;
            mm_nxt    = START_MM;
            ss_nxt    = START_SS;
        end else begin
            case (state)
                IDLE, PAUSE: begin
                    if (start) begin
                        if (cur_t != T_ZERO) begin
                            state_nxt = RUN;
                        end else begin
                            state_nxt   = EXPIRED;
                            timeout_nxt = 1'b1;
                        end
                    end else if (state == PAUSE && bonus) begin
                        {mm_nxt, ss_nxt} = t_add;
                    end
                end
                RUN: begin
                    if (pause) begin
                        state_nxt = PAUSE;
                    end else if (bonus && tick) begin
                        {mm_nxt, ss_nxt} = t_both;
                    end else if (bonus) begin
                        {mm_nxt, ss_nxt} = t_add;
                    end else if (tick) begin
                        {mm_nxt, ss_nxt} = t_dec;
                        if (t_dec == T_ZERO) begin
                            state_nxt   = EXPIRED;
                            timeout_nxt = 1'b1;
                        end
                    end
                end
                EXPIRED: state_nxt = EXPIRED;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Digit select from the top two refresh bits: ss ones, ss tens, mm ones, mm tens.
    always_comb begin
        digit_idx_c = scan_cnt[SCAN_W-1 -: 2];
        case (digit_idx_c)
            2'd0:    nib_c = ss[3:0];
            2'd1:    nib_c = ss[7:4];
            2'd2:    nib_c = mm[3:0];
            default: nib_c = mm[7:4];
        endcase
        an_c  = ~(4'b0001 << digit_idx_c);
        seg_c = seg_decode(nib_c);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mm       <= START_MM;
            ss       <= START_SS;
            running  <= 1'b0;
            expired  <= 1'b0;
            timeout  <= 1'b0;
            scan_cnt <= '0;
            an       <= 4'b1110;
            seg      <= seg_decode(START_SS[3:0]);
        end else begin
            mm       <= mm_nxt;
            ss       <= ss_nxt;
            running  <= (state_nxt == RUN);
            expired  <= (state_nxt == EXPIRED);
            timeout  <= timeout_nxt;
            scan_cnt <= scan_cnt + SCAN_W'(1);
            an       <= an_c;
            seg      <= seg_c;
        end
    end

endmodule

// File: tb/tb_game_timer.sv
// Bench for game_timer: three parameterisations share one stimulus stream and are
// checked by directed scenarios and against a seconds-based reference model.
module tb_game_timer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, tick, start, pause, load, bonus;
    logic [7:0] mm_o  [3];
    logic [7:0] ss_o  [3];
    logic       run_o [3];
    logic       exp_o [3];
    logic       to_o  [3];
    logic [3:0] an_o  [3];
    logic [6:0] seg_o [3];

    game_timer u0 (
        .clk(clk), .rst(rst), .tick(tick), .start(start), .pause(pause), .load(load), .bonus(bonus),
        .mm(mm_o[0]), .ss(ss_o[0]), .running(run_o[0]), .expired(exp_o[0]), .timeout(to_o[0]),
        .an(an_o[0]), .seg(seg_o[0])
    );

    game_timer #(.START_MM(8'h00), .START_SS(8'h02), .SCAN_W(4)) u1 (
        .clk(clk), .rst(rst), .tick(tick), .start(start), .pause(pause), .load(load), .bonus(bonus),
        .mm(mm_o[1]), .ss(ss_o[1]), .running(run_o[1]), .expired(exp_o[1]), .timeout(to_o[1]),
        .an(an_o[1]), .seg(seg_o[1])
    );

    game_timer #(.START_MM(8'h12), .START_SS(8'h34), .SCAN_W(4)) u2 (
        .clk(clk), .rst(rst), .tick(tick), .start(start), .pause(pause), .load(load), .bonus(bonus),
        .mm(mm_o[2]), .ss(ss_o[2]), .running(run_o[2]), .expired(exp_o[2]), .timeout(to_o[2]),
        .an(an_o[2]), .seg(seg_o[2])
    );

    int n_tests = 0;
    int n_fail  = 0;

    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_EXP = 3;
    localparam int MAX_SECS = 99 * 60 + 59;

    int         start_secs [3] = '{120, 2, 754};
    int         scan_w     [3] = '{17, 4, 4};
    logic [6:0] seg_tab    [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    // Reference model: time kept as plain total seconds.
    int         m_secs [3];
    int         m_st   [3];
    int         m_cnt  [3];
    logic       m_to   [3];
    logic [3:0] m_an   [3];
    logic [6:0] m_seg  [3];

    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic logic [6:0] seg_of(input int d);
        if (d > 9) return 7'h7f;
        return seg_tab[d];
    endfunction

    task automatic model_step(input logic r, t, s, p, l, b);
        for (int i = 0; i < 3; i++) begin
            if (r) begin
                m_secs[i] = start_secs[i];
                m_st[i]   = M_IDLE;
                m_to[i]   = 1'b0;
                m_cnt[i]  = 0;
                m_an[i]   = 4'b1110;
                m_seg[i]  = seg_of((start_secs[i] % 60) % 10);
            end else begin
                int idx, digit, mmv, ssv;
                mmv = m_secs[i] / 60;
                ssv = m_secs[i] % 60;
                idx = m_cnt[i] >> (scan_w[i] - 2);
                case (idx)
                    0:       digit = ssv % 10;
                    1:       digit = ssv / 10;
                    2:       digit = mmv % 10;
                    default: digit = mmv / 10;
                endcase
                m_an[i]  = 4'b1111 ^ (4'b0001 << idx);
                m_seg[i] = seg_of(digit);
                m_cnt[i] = (m_cnt[i] + 1) % (1 << scan_w[i]);
                m_to[i]  = 1'b0;
                if (l) begin
                    m_secs[i] = start_secs[i];
                    m_st[i]   = M_IDLE;
                end else if (s && (m_st[i] == M_IDLE || m_st[i] == M_PAUSE)) begin
                    if (m_secs[i] != 0) m_st[i] = M_RUN;
                    else begin m_st[i] = M_EXP; m_to[i] = 1'b1; end
                end else if (p && m_st[i] == M_RUN) begin
                    m_st[i] = M_PAUSE;
                end else if (m_st[i] == M_RUN) begin
                    m_secs[i] = m_secs[i] + (b ? 10 : 0) - (t ? 1 : 0);
                    if (m_secs[i] > MAX_SECS) m_secs[i] = MAX_SECS;
                    if (m_secs[i] == 0) begin m_st[i] = M_EXP; m_to[i] = 1'b1; end
                end else if (m_st[i] == M_PAUSE && b) begin
                    m_secs[i] = m_secs[i] + 10;
                    if (m_secs[i] > MAX_SECS) m_secs[i] = MAX_SECS;
                end
            end
        end
    endtask

    // One clock: drive inputs, advance the model, sample 1 ns after the edge.
    task automatic cycle(input logic r, t, s, p, l, b);
        rst = r; tick = t; start = s; pause = p; load = l; bonus = b;
        @(posedge clk);
        model_step(r, t, s, p, l, b);
        #1;
    endtask

    task automatic do_reset();
        cycle(1, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        logic [15:0] want_t   [3] = '{16'h0200, 16'h0002, 16'h1234};
        logic [6:0]  want_seg [3] = '{7'b1000000, 7'b0100100, 7'b0011001};
        do_reset();
        cycle(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if ({mm_o[i], ss_o[i], run_o[i], exp_o[i], to_o[i], an_o[i], seg_o[i]} !==
                {want_t[i], 3'b000, 4'b1110, want_seg[i]}) begin
                n_fail++;
                $display("FAIL reset u%0d: got %h:%h run=%b exp=%b to=%b an=%b seg=%b, want %h run=0 exp=0 to=0 an=1110 seg=%b",
                         i, mm_o[i], ss_o[i], run_o[i], exp_o[i], to_o[i], an_o[i], seg_o[i], want_t[i], want_seg[i]);
            end
        end
    endtask

    task automatic test_countdown();
        logic [15:0] want [4] = '{16'h0200, 16'h0159, 16'h0158, 16'h0157};
        do_reset();
        for (int k = 0; k < 4; k++) begin
            if (k == 0) cycle(0, 0, 1, 0, 0, 0);
            else        cycle(0, 1, 0, 0, 0, 0);
            n_tests++;
            if ({mm_o[0], ss_o[0]} !== want[k] || run_o[0] !== 1'b1) begin
                n_fail++;
                $display("FAIL countdown step%0d: got %h:%h run=%b, want %h run=1", k, mm_o[0], ss_o[0], run_o[0], want[k]);
            end
        end
    endtask

    task automatic test_expire();
        // Per step: time, running, expired, timeout on u1 (starts at 00:02).
        logic [15:0] want_t [7] = '{16'h0002, 16'h0002, 16'h0001, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        logic [2:0]  want_f [7] = '{3'b000, 3'b100, 3'b100, 3'b011, 3'b010, 3'b010, 3'b010};
        do_reset();
        for (int k = 0; k < 7; k++) begin
            case (k)
                0:       cycle(0, 0, 0, 0, 1, 0);
                1:       cycle(0, 0, 1, 0, 0, 0);
                2, 3:    cycle(0, 1, 0, 0, 0, 0);
                4:       cycle(0, 0, 0, 0, 0, 0);
                5:       cycle(0, 1, 0, 0, 0, 0);
                default: cycle(0, 1, 1, 0, 0, 1);
            endcase
            n_tests++;
            if ({mm_o[1], ss_o[1]} !== want_t[k] || {run_o[1], exp_o[1], to_o[1]} !== want_f[k]) begin
                n_fail++;
                $display("FAIL expire step%0d: got %h:%h run/exp/to=%b%b%b, want %h %b",
                         k, mm_o[1], ss_o[1], run_o[1], exp_o[1], to_o[1], want_t[k], want_f[k]);
            end
        end
    endtask

    task automatic test_pause();
        do_reset();
        cycle(0, 0, 1, 0, 0, 0);
        for (int k = 0; k < 60; k++) cycle(0, 1, 0, 0, 0, 0);
        n_tests++;
        if ({mm_o[0], ss_o[0]} !== 16'h0100 || run_o[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL pause_setup: got %h:%h run=%b, want 0100 run=1", mm_o[0], ss_o[0], run_o[0]);
        end
        cycle(0, 0, 0, 1, 0, 0);
        for (int k = 0; k < 5; k++) cycle(0, 1, 0, 0, 0, 0);
        n_tests++;
        if ({mm_o[0], ss_o[0]} !== 16'h0100 || run_o[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL pause_hold: got %h:%h run=%b, want 0100 run=0", mm_o[0], ss_o[0], run_o[0]);
        end
        cycle(0, 0, 1, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 0);
        n_tests++;
        if ({mm_o[0], ss_o[0]} !== 16'h0059 || run_o[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL pause_resume: got %h:%h run=%b, want 0059 run=1", mm_o[0], ss_o[0], run_o[0]);
        end
    endtask

    task automatic test_bonus();
        do_reset();
        cycle(0, 0, 0, 0, 0, 1);
        n_tests++;
        if ({mm_o[0], ss_o[0]} !== 16'h0200) begin
            n_fail++;
            $display("FAIL bonus_idle: got %h:%h, want 0200", mm_o[0], ss_o[0]);
        end
        cycle(0, 0, 1, 0, 0, 0);
        for (int k = 0; k < 65; k++) cycle(0, 1, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 0, 1);
        n_tests++;
        if ({mm_o[0], ss_o[0]} !== 16'h0105 || run_o[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL bonus_pause: got %h:%h run=%b, want 0105 run=0", mm_o[0], ss_o[0], run_o[0]);
        end
        cycle(0, 0, 1, 0, 0, 0);
        for (int k = 0; k < 35; k++) cycle(0, 1, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 1);
        n_tests++;
        if ({mm_o[0], ss_o[0]} !== 16'h0039 || run_o[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL bonus_tick: got %h:%h run=%b, want 0039 run=1", mm_o[0], ss_o[0], run_o[0]);
        end
        for (int k = 0; k < 4; k++) cycle(0, 1, 0, 0, 0, 0);
        for (int k = 0; k < 596; k++) cycle(0, 0, 0, 0, 0, 1);
        n_tests++;
        if ({mm_o[0], ss_o[0]} !== 16'h9955) begin
            n_fail++;
            $display("FAIL bonus_climb: got %h:%h, want 9955", mm_o[0], ss_o[0]);
        end
        cycle(0, 0, 0, 0, 0, 1);
        n_tests++;
        if ({mm_o[0], ss_o[0]} !== 16'h9959) begin
            n_fail++;
            $display("FAIL bonus_sat: got %h:%h, want 9959", mm_o[0], ss_o[0]);
        end
        cycle(0, 1, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 1);
        n_tests++;
        if ({mm_o[0], ss_o[0]} !== 16'h9959 || run_o[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL bonus_tick_sat: got %h:%h run=%b, want 9959 run=1", mm_o[0], ss_o[0], run_o[0]);
        end
    endtask

    task automatic test_display();
        logic [6:0] want_seg [4] = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};
        logic [3:0] want_an;
        do_reset();
        for (int k = 0; k < 16; k++) begin
            cycle(0, 0, 0, 0, 0, 0);
            want_an = 4'b1111 ^ (4'b0001 << (k / 4));
            n_tests++;
            if (an_o[2] !== want_an || seg_o[2] !== want_seg[k / 4]) begin
                n_fail++;
                $display("FAIL display cyc%0d: got an=%b seg=%b, want an=%b seg=%b",
                         k, an_o[2], seg_o[2], want_an, want_seg[k / 4]);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        cycle(0, 0, 1, 0, 0, 0);
        for (int k = 0; k < 37; k++) cycle(0, 1, 0, 0, 0, 0);
        n_tests++;
        if ({mm_o[0], ss_o[0]} !== 16'h0123 || run_o[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_setup: got %h:%h run=%b, want 0123 run=1", mm_o[0], ss_o[0], run_o[0]);
        end
        cycle(1, 1, 0, 0, 0, 0);
        n_tests++;
        if ({mm_o[0], ss_o[0]} !== 16'h0200 || {run_o[0], exp_o[0], to_o[0]} !== 3'b000) begin
            n_fail++;
            $display("FAIL rstmid_run: got %h:%h run/exp/to=%b%b%b, want 0200 000",
                     mm_o[0], ss_o[0], run_o[0], exp_o[0], to_o[0]);
        end
        cycle(0, 0, 1, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 0);
        n_tests++;
        if (to_o[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_pulse_setup: got timeout=%b, want 1", to_o[1]);
        end
        cycle(1, 0, 0, 0, 0, 0);
        n_tests++;
        if ({mm_o[1], ss_o[1]} !== 16'h0002 || {run_o[1], exp_o[1], to_o[1]} !== 3'b000) begin
            n_fail++;
            $display("FAIL rstmid_pulse: got %h:%h run/exp/to=%b%b%b, want 0002 000",
                     mm_o[1], ss_o[1], run_o[1], exp_o[1], to_o[1]);
        end
    endtask

    task automatic test_random();
        logic r, t, s, p, l, b;
        logic [33:0] want;
        do_reset();
        for (int k = 0; k < 2000; k++) begin
            r = ($urandom_range(0, 99) < 1);
            l = ($urandom_range(0, 99) < 2);
            s = ($urandom_range(0, 99) < 10);
            p = ($urandom_range(0, 99) < 6);
            b = ($urandom_range(0, 99) < 12);
            t = ($urandom_range(0, 99) < 50);
            cycle(r, t, s, p, l, b);
            for (int i = 0; i < 3; i++) begin
                want = {to_bcd(m_secs[i] / 60), to_bcd(m_secs[i] % 60), (m_st[i] == M_RUN),
                        (m_st[i] == M_EXP), m_to[i], m_an[i], m_seg[i]};
                n_tests++;
                if ({mm_o[i], ss_o[i], run_o[i], exp_o[i], to_o[i], an_o[i], seg_o[i]} !== want) begin
                    n_fail++;
                    $display("FAIL random cyc%0d u%0d: got %h:%h r/e/t=%b%b%b an=%b seg=%b, want %h:%h r/e/t=%b an=%b seg=%b",
                             k, i, mm_o[i], ss_o[i], run_o[i], exp_o[i], to_o[i], an_o[i], seg_o[i],
                             want[33:26], want[25:18], want[17:15], want[14:11], want[10:0]);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; tick = 1'b0; start = 1'b0; pause = 1'b0; load = 1'b0; bonus = 1'b0;
        test_reset();
        test_countdown();
        test_expire();
        test_pause();
        test_bonus();
        test_display();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
